// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types, limits and lane helpers for the SRAM bus model
package sram_pkg;

   typedef enum logic {INIT, READY} sram_state_e;

   localparam int MAX_READ_LATENCY = 4;
   localparam int MAX_DATA_WIDTH   = 128;
   localparam int MAX_LANES        = MAX_DATA_WIDTH / 8;

   function automatic int lanes(input int data_width);
      return data_width / 8;
   endfunction

   // Callers size-cast in and out; unused upper lanes pass through untouched.
   function automatic logic [MAX_DATA_WIDTH-1:0] lane_merge(
      input logic [MAX_DATA_WIDTH-1:0] old_word,
      input logic [MAX_DATA_WIDTH-1:0] new_word,
      input logic [MAX_LANES-1:0]      mask
   );
      logic [MAX_DATA_WIDTH-1:0] merged;
      merged = old_word;
      for (int i = 0; i < MAX_LANES; i++) begin
         if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// rtl/sram_read_pipe.sv - LATENCY-stage {valid, data, mask} shift register, passthrough when LATENCY is 0
module sram_read_pipe
   import sram_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 2,
   parameter int LATENCY    = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [LANES-1:0]      in_mask,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [LANES-1:0]      out_mask
);

   if (LATENCY == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign out_mask  = in_mask;
   end else begin : g_pipe
      logic [LATENCY-1:0]    valid_q;
      logic [DATA_WIDTH-1:0] data_q [LATENCY];
      logic [LANES-1:0]      mask_q [LATENCY];

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= '0;
         end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
         end
      end

      // Payload needs no reset: nothing downstream looks at it without valid.
      always_ff @(posedge clk) begin
         data_q[0] <= in_data;
         mask_q[0] <= in_mask;
         for (int i = 1; i < LATENCY; i++) begin
            data_q[i] <= data_q[i-1];
            mask_q[i] <= mask_q[i-1];
         end
      end

      assign out_valid = valid_q[LATENCY-1];
      assign out_data  = data_q[LATENCY-1];
      assign out_mask  = mask_q[LATENCY-1];
   end

endmodule

// File: rtl/sram_model_param.sv
// rtl/sram_model_param.sv - parametrised SRAM bus model with init sweep, byte lanes and read latency
module sram_model_param
   import sram_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 16,
   parameter int                    ADDR_WIDTH   = 18,
   parameter int                    DEPTH        = 512,
   parameter int                    READ_LATENCY = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   SRAM_ADDR,
   inout  wire  [DATA_WIDTH-1:0]   SRAM_DQ,
   input  logic                    SRAM_WE_N,
   input  logic                    SRAM_CE_N,
   input  logic                    SRAM_OE_N,
   input  logic [DATA_WIDTH/8-1:0] SRAM_BE_N,
   output logic                    init_done,
   output logic                    oob_err
);

   localparam int LANES    = lanes(DATA_WIDTH);
   localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // An out-of-range latency clamps to the deepest supported pipe.
   localparam int PIPE_LAT = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;

   sram_state_e           state;
   logic [IDX_W-1:0]      init_ptr;
   logic [IDX_W-1:0]      idx;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  in_range;
   logic                  active;
   logic                  wr_req;
   logic                  rd_req;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  pipe_valid;
   logic [DATA_WIDTH-1:0] pipe_data;
   logic [LANES-1:0]      pipe_mask;
   logic [LANES-1:0]      drive_lane;

   // Compare one bit wider so DEPTH == 2**ADDR_WIDTH does not wrap.
   assign in_range = {1'b0, SRAM_ADDR} < (ADDR_WIDTH+1)'(DEPTH);
   assign idx      = SRAM_ADDR[IDX_W-1:0];
   assign active   = (state == READY) && !SRAM_CE_N;
   assign wr_req   = active && !SRAM_WE_N;
   assign rd_req   = active && SRAM_WE_N && !SRAM_OE_N;
   assign rd_word  = in_range ? mem[idx] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT;
         init_ptr  <= '0;
         init_done <= 1'b0;
         oob_err   <= 1'b0;
      end else begin
         oob_err <= (wr_req || rd_req) && !in_range;
         if (state == INIT) begin
            if (init_ptr == IDX_W'(DEPTH - 1)) begin
               state     <= READY;
               init_done <= 1'b1;
            end else begin
               init_ptr <= init_ptr + IDX_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == INIT) begin
            mem[init_ptr] <= INIT_VALUE;
         end else if (wr_req && in_range) begin
            mem[idx] <= DATA_WIDTH'(lane_merge(MAX_DATA_WIDTH'(mem[idx]),
                                               MAX_DATA_WIDTH'(SRAM_DQ),
                                               MAX_LANES'(~SRAM_BE_N)));
         end
      end
   end

   sram_read_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES),
      .LATENCY    (PIPE_LAT)
   ) u_read_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_req),
      .in_data   (rd_word),
      .in_mask   (~SRAM_BE_N),
      .out_valid (pipe_valid),
      .out_data  (pipe_data),
      .out_mask  (pipe_mask)
   );

   // Never drive while the controller may be driving a write.
   assign drive_lane = (pipe_valid && SRAM_WE_N && !rst) ? pipe_mask : '0;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign SRAM_DQ[8*i +: 8] = drive_lane[i] ? pipe_data[8*i +: 8] : 8'bz;
   end

endmodule

// File: tb/tb_sram_model_param.sv
// tb/tb_sram_model_param.sv - randomized reference-model bench for sram_model_param (L=0/DEPTH=8 and L=2/DEPTH=512)
module tb_sram_model_param;

   localparam int          AW     = 18;
   localparam logic [15:0] INIT_V = 16'hA5A5;
   localparam logic [15:0] BUS_Z  = 16'hFFFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [AW-1:0] addr;
   logic          we_n, ce_n, oe_n;
   logic [1:0]    be_n;
   logic [15:0]   wdata;
   tri1  [15:0]   dq_a;
   tri1  [15:0]   dq_b;
   logic          init_done_a, init_done_b, oob_a, oob_b;

   assign dq_a = we_n ? 16'bz : wdata;
   assign dq_b = we_n ? 16'bz : wdata;

   sram_model_param #(.DATA_WIDTH(16), .ADDR_WIDTH(AW), .DEPTH(8), .READ_LATENCY(0), .INIT_VALUE(INIT_V)) u_dut_a (
      .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq_a), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n),
      .SRAM_OE_N(oe_n), .SRAM_BE_N(be_n), .init_done(init_done_a), .oob_err(oob_a));

   sram_model_param #(.DATA_WIDTH(16), .ADDR_WIDTH(AW), .DEPTH(512), .READ_LATENCY(2), .INIT_VALUE(INIT_V)) u_dut_b (
      .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq_b), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n),
      .SRAM_OE_N(oe_n), .SRAM_BE_N(be_n), .init_done(init_done_b), .oob_err(oob_b));

   // Reference model: index 0 mirrors u_dut_a, index 1 mirrors u_dut_b.
   int          depth [2] = '{8, 512};
   int          lat   [2] = '{0, 2};
   logic [15:0] mem   [2][512];
   int          edges [2];
   bit          ready [2];
   bit          oob_exp [2];
   bit          sch_v [2][8];
   logic [15:0] sch_d [2][8];
   logic [1:0]  sch_m [2][8];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic [AW-1:0] a, input logic w, input logic c,
                       input logic o, input logic [1:0] b, input logic [15:0] d);
      logic [15:0] exp_dq;
      logic [15:0] rd_word;
      bit          rd, wr, inr;
      int          slot;
      @(negedge clk);
      rst = r; addr = a; we_n = w; ce_n = c; oe_n = o; be_n = b; wdata = d;
      #1;
      slot = cyc % 8;
      for (int k = 0; k < 2; k++) begin
         inr     = (a < depth[k]);
         wr      = !r && ready[k] && !c && !w;
         rd      = !r && ready[k] && !c && w && !o;
         rd_word = inr ? mem[k][a[8:0]] : 16'h0000;
         if (rd && lat[k] == 0) begin
            sch_v[k][slot] = 1'b1; sch_d[k][slot] = rd_word; sch_m[k][slot] = ~b;
         end
         exp_dq = BUS_Z;
         if (!w) exp_dq = d;
         else if (!r && sch_v[k][slot])
            for (int l = 0; l < 2; l++)
               if (sch_m[k][slot][l]) exp_dq[8*l +: 8] = sch_d[k][slot][8*l +: 8];
         check(k == 0 ? "dq_a" : "dq_b", k == 0 ? dq_a : dq_b, exp_dq);
         check(k == 0 ? "init_done_a" : "init_done_b", k == 0 ? init_done_a : init_done_b, ready[k]);
         check(k == 0 ? "oob_err_a" : "oob_err_b", k == 0 ? oob_a : oob_b, oob_exp[k]);

         sch_v[k][slot] = 1'b0;
         if (r) begin
            edges[k] = 0; ready[k] = 1'b0; oob_exp[k] = 1'b0;
            for (int s = 0; s < 8; s++) sch_v[k][s] = 1'b0;
         end else if (!ready[k]) begin
            oob_exp[k] = 1'b0;
            edges[k]++;
            if (edges[k] == depth[k]) begin
               ready[k] = 1'b1;
               for (int i = 0; i < depth[k]; i++) mem[k][i] = INIT_V;
            end
         end else begin
            oob_exp[k] = (wr || rd) && !inr;
            if (rd && lat[k] > 0) begin
               sch_v[k][(cyc + lat[k]) % 8] = 1'b1;
               sch_d[k][(cyc + lat[k]) % 8] = rd_word;
               sch_m[k][(cyc + lat[k]) % 8] = ~b;
            end
            if (wr && inr)
               for (int l = 0; l < 2; l++)
                  if (!b[l]) mem[k][a[8:0]][8*l +: 8] = d[8*l +: 8];
         end
      end
      cyc++;
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b1, 1'b1, 1'b1, 2'b11, 16'h0000);
   endtask

   logic [AW-1:0] r_addr;
   logic [15:0]   r_data;

   initial begin
      rst = 1'b1; addr = '0; we_n = 1'b1; ce_n = 1'b1; oe_n = 1'b1; be_n = 2'b11; wdata = '0;
      for (int k = 0; k < 2; k++) begin
         edges[k] = 0; ready[k] = 1'b0; oob_exp[k] = 1'b0;
         for (int s = 0; s < 8; s++) sch_v[k][s] = 1'b0;
      end
      repeat (2) @(posedge clk);

      step(1'b1, '0, 1'b1, 1'b1, 1'b1, 2'b11, 16'h0);
      for (int i = 0; i < 3; i++) step(1'b0, AW'(i), 1'b0, 1'b0, 1'b1, 2'b00, 16'h0BAD);
      step(1'b1, '0, 1'b1, 1'b1, 1'b1, 2'b11, 16'h0);
      for (int i = 0; i < 8; i++) step(1'b0, AW'(i), 1'(i % 2), 1'b0, 1'b0, 2'b00, 16'h0BAD);
      check("init_done_a_pre", init_done_a, 1'b0);
      @(posedge clk); #1;
      check("init_done_a_rise", init_done_a, 1'b1);

      for (int i = 0; i < 8; i++) begin
         step(1'b0, AW'(i), 1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
         check("init_word_a", dq_a, INIT_V);
      end

      step(1'b0, 18'd5, 1'b0, 1'b0, 1'b1, 2'b00, 16'h1234);
      step(1'b0, 18'd5, 1'b0, 1'b0, 1'b1, 2'b10, 16'hBEEF);
      step(1'b0, 18'd5, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
      check("lane_merge", dq_a, 16'h12EF);
      step(1'b0, 18'd5, 1'b1, 1'b0, 1'b0, 2'b01, 16'h0);
      check("lane_z", dq_a, 16'h12FF);

      step(1'b0, 18'd2, 1'b0, 1'b1, 1'b1, 2'b00, 16'h4444);
      step(1'b0, 18'd2, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
      check("ce_gate", dq_a, INIT_V);

      for (int n = 0; n < 600 && !init_done_b; n++) idle();
      check("init_done_b", init_done_b, 1'b1);

      step(1'b0, 18'd1, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0011);
      step(1'b0, 18'd2, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0022);
      step(1'b0, 18'd3, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0033);
      step(1'b0, 18'd1, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
      check("lat_pre0", dq_b, BUS_Z);
      step(1'b0, 18'd2, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
      check("lat_pre1", dq_b, BUS_Z);
      step(1'b0, 18'd3, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
      check("lat_d1", dq_b, 16'h0011);
      idle(); check("lat_d2", dq_b, 16'h0022);
      idle(); check("lat_d3", dq_b, 16'h0033);
      idle(); check("lat_post", dq_b, BUS_Z);

      step(1'b0, 18'd1, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
      idle();
      step(1'b0, 18'd4, 1'b0, 1'b0, 1'b1, 2'b00, 16'h7777);
      check("guard_bus", dq_b, 16'h7777);
      idle(); check("guard_after", dq_b, BUS_Z);
      step(1'b0, 18'd4, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
      idle(); idle();
      check("guard_rd", dq_b, 16'h7777);

      step(1'b0, 18'd600, 1'b0, 1'b0, 1'b1, 2'b00, 16'hFFFF);
      idle();
      check("oob_pulse_b", oob_b, 1'b1);
      check("oob_pulse_a", oob_a, 1'b1);
      idle();
      check("oob_clear_b", oob_b, 1'b0);
      step(1'b0, 18'd600, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
      check("oob_rd_a", dq_a, 16'h0000);
      idle(); idle();
      check("oob_rd_b", dq_b, 16'h0000);
      step(1'b0, 18'd88, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
      idle(); idle();
      check("oob_alias", dq_b, INIT_V);

      for (int n = 0; n < 2000; n++) begin
         r_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(500, 700)) : AW'($urandom_range(0, 15));
         r_data = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 254))};
         step(1'b0, r_addr, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0,
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), r_data);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
